// File: rtl/wshb_arb_pkg.sv
// Shared types and default sizes for the two-requester Wishbone SDRAM arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int unsigned DATA_BYTES_DEF = 4;
    localparam int unsigned ADDR_W_DEF     = 32;

endpackage

// File: rtl/wshb_arb_fsm.sv
// Grant FSM: holds a grant for a whole Wishbone cycle and hands over back-to-back.
// Define WSHB_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority for requester 0.
module wshb_arb_fsm
    import wshb_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cyc,
    output logic [1:0] gnt
);

    arb_state_t state_q, state_d;
    logic [1:0] gnt_q;
    logic       tie_to_1;

`ifdef WSHB_ARB_FIXED_PRIO_EN
    assign tie_to_1 = 1'b0;
`else
    logic rr_q;
    assign tie_to_1 = rr_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cyc[0] && cyc[1]) begin
                    state_d = tie_to_1 ? GNT1 : GNT0;
                end else if (cyc[0]) begin
                    state_d = GNT0;
                end else if (cyc[1]) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!cyc[0]) begin
                    state_d = cyc[1] ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!cyc[1]) begin
                    state_d = cyc[0] ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant is registered from the next state so it lines up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
`ifndef WSHB_ARB_FIXED_PRIO_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= {state_d == GNT1, state_d == GNT0};
`ifndef WSHB_ARB_FIXED_PRIO_EN
            if (state_d == GNT0) begin
                rr_q <= 1'b1;
            end else if (state_d == GNT1) begin
                rr_q <= 1'b0;
            end
`endif
        end
    end

    assign gnt = gnt_q;

endmodule

// File: rtl/wshb_arbiter.sv
// Two-requester Wishbone arbiter in front of the SDRAM slave port; grant-steered muxes only.
// Build option WSHB_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) instead of round-robin.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int unsigned DATA_BYTES = DATA_BYTES_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,

    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    input  logic [ADDR_W-1:0]       m0_adr,
    input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
    input  logic [DATA_BYTES-1:0]   m0_sel,
    output logic [8*DATA_BYTES-1:0] m0_dat_sm,
    output logic                    m0_ack,
    output logic                    m0_stall,

    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    input  logic [ADDR_W-1:0]       m1_adr,
    input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
    input  logic [DATA_BYTES-1:0]   m1_sel,
    output logic [8*DATA_BYTES-1:0] m1_dat_sm,
    output logic                    m1_ack,
    output logic                    m1_stall,

    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [ADDR_W-1:0]       s_adr,
    output logic [8*DATA_BYTES-1:0] s_dat_ms,
    output logic [DATA_BYTES-1:0]   s_sel,
    input  logic [8*DATA_BYTES-1:0] s_dat_sm,
    input  logic                    s_ack,
    input  logic                    s_stall
);

    logic [1:0] gnt;

    wshb_arb_fsm u_fsm (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .cyc   ({m1_cyc, m0_cyc}),
        .gnt   (gnt)
    );

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        if (gnt[0]) begin
            s_cyc    = m0_cyc;
            s_stb    = m0_stb;
            s_we     = m0_we;
            s_adr    = m0_adr;
            s_dat_ms = m0_dat_ms;
            s_sel    = m0_sel;
        end else if (gnt[1]) begin
            s_cyc    = m1_cyc;
            s_stb    = m1_stb;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_dat_ms = m1_dat_ms;
            s_sel    = m1_sel;
        end
    end

    // Read data is broadcast; only the granted requester sees ack.
    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;
    assign m0_ack    = s_ack & gnt[0];
    assign m1_ack    = s_ack & gnt[1];
    assign m0_stall  = gnt[0] ? s_stall : 1'b1;
    assign m1_stall  = gnt[1] ? s_stall : 1'b1;

endmodule
